// File: rtl/layer7_seq_pkg.sv
// Shared types for the layer-7 sequencer: FSM states, DMA select codes, default sizes.
// Latency/backpressure: n/a (declarations only); LAYER7_SEQ_TIMEOUT_EN enables the ERR path.
package layer7_seq_pkg;

  localparam int NUM_CLASSES_DEF    = 10;
  localparam int WORD_DEF           = 16;
  localparam int BIAS_SETTLE_DEF    = 12;
  localparam int TIMEOUT_CYCLES_DEF = 4096;
  localparam int IDX_W              = 4;

  localparam logic [1:0] SEL_BIAS   = 2'b00;
  localparam logic [1:0] SEL_WEIGHT = 2'b01;
  localparam logic [1:0] SEL_PIXEL  = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_B_LOAD,
    ST_B_SETTLE,
    ST_W_LOAD,
    ST_P_LOAD,
    ST_RUN,
    ST_ARGMAX,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic logic is_watched(input state_e s);
    return (s == ST_B_LOAD) || (s == ST_W_LOAD) || (s == ST_P_LOAD) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/layer7_argmax_unit.sv
// Captures the FC result vector on start, then scans one channel per cycle for the signed maximum.
// Latency: done high NUM_CLASSES cycles after start; no backpressure, start must not repeat mid-scan.
module layer7_argmax_unit
  import layer7_seq_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int WORD        = WORD_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [WORD*NUM_CLASSES-1:0] fc_result,
  output logic                        done,
  output logic [IDX_W-1:0]            idx,
  output logic [WORD-1:0]             score
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  logic [WORD-1:0]  cap_q [NUM_CLASSES];
  logic [WORD-1:0]  cap_d [NUM_CLASSES];
  logic             run_q, run_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WORD-1:0]  score_q, score_d;

  always_comb begin
    cap_d   = cap_q;
    run_d   = run_q;
    k_d     = k_q;
    idx_d   = idx_q;
    score_d = score_q;
    if (start) begin
      for (int i = 0; i < NUM_CLASSES; i++) cap_d[i] = fc_result[WORD*i +: WORD];
      run_d   = 1'b1;
      k_d     = '0;
      idx_d   = '0;
      score_d = fc_result[WORD-1:0];
    end else if (run_q) begin
      // Strictly greater keeps the lowest index on ties.
      if ($signed(cap_q[k_q]) > $signed(score_q)) begin
        idx_d   = k_q;
        score_d = cap_q[k_q];
      end
      if (k_q == LAST) run_d = 1'b0;
      else             k_d   = k_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CLASSES; i++) cap_q[i] <= '0;
      run_q   <= 1'b0;
      k_q     <= '0;
      idx_q   <= '0;
      score_q <= '0;
    end else begin
      cap_q   <= cap_d;
      run_q   <= run_d;
      k_q     <= k_d;
      idx_q   <= idx_d;
      score_q <= score_d;
    end
  end

  assign done  = run_q && (k_q == LAST);
  assign idx   = idx_q;
  assign score = score_q;

endmodule

// File: rtl/layer7_seq_ctrl.sv
// Layer-7 sequencer: bias/weight/pixel DMA loads, FC run, signed argmax, irq; watchdog via LAYER7_SEQ_TIMEOUT_EN.
// Latency: loads + BIAS_SETTLE + FC run + NUM_CLASSES + 1; waits on dma_done/calc_done, start ignored while busy.
module layer7_seq_ctrl
  import layer7_seq_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int WORD        = WORD_DEF,
  parameter int BIAS_SETTLE = BIAS_SETTLE_DEF
`ifdef LAYER7_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        dma_req,
  output logic [1:0]                  dma_sel,
  input  logic                        dma_done,
  output logic                        bias_store_done,
  output logic                        weight_store_done,
  output logic                        pixel_store_done,
  input  logic                        layer7_calc_done,
  input  logic [WORD*NUM_CLASSES-1:0] fc_result,
  output logic                        busy,
  output logic [IDX_W-1:0]            class_idx,
  output logic [WORD-1:0]             class_score,
  output logic                        class_valid,
  output logic                        irq,
  output logic                        err
);

  localparam int SETTLE_W = $clog2(BIAS_SETTLE + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(BIAS_SETTLE - 1);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [1:0]          sel_q, sel_d;
  logic                bsd_q, bsd_d, wsd_q, wsd_d, psd_q, psd_d;
  logic                busy_q, busy_d;
  logic                valid_q, valid_d;
  logic                irq_q, irq_d;
  logic                err_q, err_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic                am_start, am_done;

`ifdef LAYER7_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    sel_d    = sel_q;
    bsd_d    = 1'b0;
    wsd_d    = 1'b0;
    psd_d    = 1'b0;
    busy_d   = busy_q;
    valid_d  = valid_q;
    irq_d    = 1'b0;
    err_d    = err_q;
    settle_d = settle_q;
    am_start = 1'b0;
    // Every load exits with req low for a cycle; W/P re-raise req on their second cycle.
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: if (start) begin
        state_d = ST_B_LOAD; req_d = 1'b1; sel_d = SEL_BIAS;
        busy_d = 1'b1; valid_d = 1'b0; err_d = 1'b0;
      end
      ST_B_LOAD: if (dma_done && req_q) begin
        state_d = ST_B_SETTLE; req_d = 1'b0; bsd_d = 1'b1; settle_d = '0;
      end else req_d = 1'b1;
      ST_B_SETTLE: if (settle_q == SETTLE_LAST) begin
        state_d = ST_W_LOAD; sel_d = SEL_WEIGHT;
      end else settle_d = settle_q + 1'b1;
      ST_W_LOAD: if (dma_done && req_q) begin
        state_d = ST_P_LOAD; req_d = 1'b0; wsd_d = 1'b1; sel_d = SEL_PIXEL;
      end else req_d = 1'b1;
      ST_P_LOAD: if (dma_done && req_q) begin
        state_d = ST_RUN; req_d = 1'b0; psd_d = 1'b1;
      end else req_d = 1'b1;
      ST_RUN: if (layer7_calc_done) begin
        state_d = ST_ARGMAX; am_start = 1'b1;
      end
      ST_ARGMAX: if (am_done) begin
        state_d = ST_DONE; busy_d = 1'b0; valid_d = 1'b1; irq_d = 1'b1;
      end
      default: ;
    endcase
`ifdef LAYER7_SEQ_TIMEOUT_EN
    wd_d = wd_q;
    if (state_d != state_q) wd_d = '0;
    else if (is_watched(state_q)) begin
      if (wd_q == WD_LAST) begin
        state_d = ST_ERR; req_d = 1'b0; busy_d = 1'b0;
        err_d = 1'b1; irq_d = 1'b1; wd_d = '0;
      end else wd_d = wd_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      sel_q    <= SEL_BIAS;
      bsd_q    <= 1'b0;
      wsd_q    <= 1'b0;
      psd_q    <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      irq_q    <= 1'b0;
      err_q    <= 1'b0;
      settle_q <= '0;
`ifdef LAYER7_SEQ_TIMEOUT_EN
      wd_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      sel_q    <= sel_d;
      bsd_q    <= bsd_d;
      wsd_q    <= wsd_d;
      psd_q    <= psd_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      irq_q    <= irq_d;
      err_q    <= err_d;
      settle_q <= settle_d;
`ifdef LAYER7_SEQ_TIMEOUT_EN
      wd_q     <= wd_d;
`endif
    end
  end

  layer7_argmax_unit #(
    .NUM_CLASSES(NUM_CLASSES),
    .WORD       (WORD)
  ) u_argmax (
    .clk      (clk),
    .rst      (rst),
    .start    (am_start),
    .fc_result(fc_result),
    .done     (am_done),
    .idx      (class_idx),
    .score    (class_score)
  );

  assign dma_req           = req_q;
  assign dma_sel           = sel_q;
  assign bias_store_done   = bsd_q;
  assign weight_store_done = wsd_q;
  assign pixel_store_done  = psd_q;
  assign busy              = busy_q;
  assign class_valid       = valid_q;
  assign irq               = irq_q;
`ifdef LAYER7_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
  logic unused_err;
  assign unused_err = err_q ^ err_d;
`endif

endmodule
